// File: rtl/muldiv_sequencer_if.sv
// Multiply/divide request/result bundle between the control unit
// and the muldiv sequencer.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic             hi_lo_write;
   logic             div_zero;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;

   modport master (
      output start, op, a_in, b_in,
      input  busy, done, hi_lo_write, div_zero, hi_out, lo_out
   );

   modport slave (
      input  start, op, a_in, b_in,
      output busy, done, hi_lo_write, div_zero, hi_out, lo_out
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring) unit
// with its own sequencing FSM feeding HI/LO.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input logic              clk,
   input logic              reset,
   muldiv_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MULT,
      S_DIV,
      S_FINISH,
      S_DZERO
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   // acc_q carries a guard bit so that subtracting the most negative
   // multiplicand cannot overflow; in DIV it holds the partial remainder.
   logic [WIDTH:0]   m_q;
   logic [WIDTH:0]   acc_q;
   logic [WIDTH-1:0] qr_q;
   logic             qm1_q;
   logic             rneg_q;
   logic             qneg_q;
   logic             busy_q;
   logic             done_q;
   logic             hlw_q;
   logic             dz_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic [WIDTH:0]   bsum_d;
   logic [WIDTH:0]   bacc_d;
   logic [WIDTH-1:0] bqr_d;
   logic             bqm1_d;
   logic [WIDTH:0]   trial_d;
   logic [WIDTH:0]   diff_d;
   logic [WIDTH-1:0] drem_d;
   logic [WIDTH-1:0] dquo_d;
   logic [WIDTH-1:0] qfix_d;
   logic [WIDTH-1:0] rfix_d;
   logic [WIDTH-1:0] a_mag_d;
   logic [WIDTH-1:0] b_mag_d;
   logic             last_d;

   // Datapath for one Booth step, one restoring step and the sign fix.
   always_comb begin
      bsum_d = acc_q;
      case ({qr_q[0], qm1_q})
         2'b01:   bsum_d = acc_q + m_q;
         2'b10:   bsum_d = acc_q - m_q;
         default: bsum_d = acc_q;
      endcase
      {bacc_d, bqr_d, bqm1_d} = {bsum_d[WIDTH], bsum_d, qr_q};

      trial_d = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
      diff_d  = trial_d - m_q;
      if (diff_d[WIDTH]) begin
         drem_d = trial_d[WIDTH-1:0];
         dquo_d = {qr_q[WIDTH-2:0], 1'b0};
      end else begin
         drem_d = diff_d[WIDTH-1:0];
         dquo_d = {qr_q[WIDTH-2:0], 1'b1};
      end
      qfix_d = qneg_q ? -dquo_d : dquo_d;
      rfix_d = rneg_q ? -drem_d : drem_d;

      a_mag_d = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
      b_mag_d = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
      last_d  = (cnt_q == CW'(WIDTH - 1));
   end

   // Sequencing FSM with registered pulses and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         m_q     <= '0;
         acc_q   <= '0;
         qr_q    <= '0;
         qm1_q   <= 1'b0;
         rneg_q  <= 1'b0;
         qneg_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hlw_q   <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         done_q <= 1'b0;
         hlw_q  <= 1'b0;
         dz_q   <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  busy_q <= 1'b1;
                  cnt_q  <= '0;
                  acc_q  <= '0;
                  qm1_q  <= 1'b0;
                  if (!bus.op) begin
                     state_q <= S_MULT;
                     m_q     <= {bus.a_in[WIDTH-1], bus.a_in};
                     qr_q    <= bus.b_in;
                  end else if (bus.b_in == '0) begin
                     state_q <= S_DZERO;
                     done_q  <= 1'b1;
                     dz_q    <= 1'b1;
                  end else begin
                     state_q <= S_DIV;
                     m_q     <= {1'b0, b_mag_d};
                     qr_q    <= a_mag_d;
                     rneg_q  <= bus.a_in[WIDTH-1];
                     qneg_q  <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
                  end
               end
            end
            S_MULT: begin
               acc_q <= bacc_d;
               qr_q  <= bqr_d;
               qm1_q <= bqm1_d;
               cnt_q <= cnt_q + 1'b1;
               if (last_d) begin
                  state_q <= S_FINISH;
                  hi_q    <= bacc_d[WIDTH-1:0];
                  lo_q    <= bqr_d;
                  done_q  <= 1'b1;
                  hlw_q   <= 1'b1;
               end
            end
            S_DIV: begin
               acc_q <= {1'b0, drem_d};
               qr_q  <= dquo_d;
               cnt_q <= cnt_q + 1'b1;
               if (last_d) begin
                  state_q <= S_FINISH;
                  hi_q    <= rfix_d;
                  lo_q    <= qfix_d;
                  done_q  <= 1'b1;
                  hlw_q   <= 1'b1;
               end
            end
            S_FINISH, S_DZERO: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.hi_lo_write = hlw_q;
   assign bus.div_zero    = dz_q;
   assign bus.hi_out      = hi_q;
   assign bus.lo_out      = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised and directed bench for muldiv_sequencer against an
// arithmetic reference model.
module tb_muldiv_sequencer;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   int   tests_run = 0;
   int   tests_failed = 0;
   logic [W-1:0] exp_hi = '0;
   logic [W-1:0] exp_lo = '0;

   muldiv_sequencer_if #(.WIDTH(W)) bus ();

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: 64-bit signed arithmetic; SV division truncates toward zero
   // and the remainder follows the dividend.
   function automatic void model(input logic o, input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 output logic [W-1:0] hi,
                                 output logic [W-1:0] lo,
                                 output logic dz);
      longint sa, sb, p, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 1'b0;
      if (!o) begin
         p = sa * sb;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == '0) begin
         dz = 1'b1;
         hi = exp_hi;
         lo = exp_lo;
      end else begin
         q = sa / sb;
         r = sa % sb;
         hi = r[31:0];
         lo = q[31:0];
      end
   endfunction

   // Starts an operation (called #1 after an edge) and returns the observed
   // result, latency in edges after the start edge, and whether the cycle
   // after done is back to quiet idle.
   task automatic run_op(input logic o, input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output int lat, output logic dz, output logic hlw,
                         output int busy_n, output logic clr);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a_in  = a;
      bus.b_in  = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.op    = 1'($urandom);
      bus.a_in  = $urandom;
      bus.b_in  = $urandom;
      lat = 0;
      busy_n = 0;
      while (!bus.done && lat < 100) begin
         if (bus.busy) busy_n++;
         @(posedge clk); #1;
         lat++;
      end
      if (bus.busy) busy_n++;
      dz  = bus.div_zero;
      hlw = bus.hi_lo_write;
      hi  = bus.hi_out;
      lo  = bus.lo_out;
      @(posedge clk); #1;
      clr = !bus.done && !bus.busy && !bus.hi_lo_write && !bus.div_zero;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.op = 1'b0;
      bus.a_in = '0;
      bus.b_in = '0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({bus.busy, bus.done, bus.hi_lo_write, bus.div_zero} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_ctl got %b want 0000",
                  {bus.busy, bus.done, bus.hi_lo_write, bus.div_zero});
      end
      tests_run++;
      if ({bus.hi_out, bus.lo_out} !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset_hilo got %h want 0", {bus.hi_out, bus.lo_out});
      end
      reset = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
   endtask

   task automatic test_directed;
      logic [W-1:0] ta [9];
      logic [W-1:0] tb [9];
      logic         to [9];
      logic [W-1:0] rh [9];
      logic [W-1:0] rl [9];
      logic [W-1:0] hi, lo, mh, ml;
      logic dz, hlw, clr, mdz;
      int lat, bn;
      ta = '{32'd7, 32'h80000000, 32'h0, 32'hFFFFFFF9, 32'd7,
             32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'd100};
      tb = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE,
             32'hFFFFFFFF, 32'h7FFFFFFF, 32'd1, 32'd7};
      to = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      rh = '{32'hFFFFFFFF, 32'h40000000, 32'h0, 32'hFFFFFFFF, 32'h1,
             32'h0, 32'h3FFFFFFF, 32'h0, 32'd2};
      rl = '{32'hFFFFFFEB, 32'h0, 32'h0, 32'hFFFFFFFD, 32'hFFFFFFFD,
             32'h80000000, 32'h00000001, 32'h80000000, 32'd14};
      for (int i = 0; i < 9; i++) begin
         model(to[i], ta[i], tb[i], mh, ml, mdz);
         run_op(to[i], ta[i], tb[i], hi, lo, lat, dz, hlw, bn, clr);
         tests_run++;
         if ({hi, lo} !== {rh[i], rl[i]} || {mh, ml} !== {rh[i], rl[i]}) begin
            tests_failed++;
            $display("FAIL directed[%0d] hi/lo got %h_%h want %h_%h",
                     i, hi, lo, rh[i], rl[i]);
         end
         tests_run++;
         if (lat !== W || bn !== W + 1 || {dz, hlw, clr} !== 3'b011) begin
            tests_failed++;
            $display("FAIL directed[%0d] timing got lat=%0d busy=%0d dz/hlw/clr=%b want lat=%0d busy=%0d 011",
                     i, lat, bn, {dz, hlw, clr}, W, W + 1);
         end
         exp_hi = rh[i];
         exp_lo = rl[i];
      end
   endtask

   task automatic test_div_zero;
      logic [W-1:0] hi, lo;
      logic dz, hlw, clr;
      int lat, bn;
      run_op(1'b1, 32'd5, 32'd0, hi, lo, lat, dz, hlw, bn, clr);
      tests_run++;
      if ({hi, lo} !== {exp_hi, exp_lo}) begin
         tests_failed++;
         $display("FAIL div_zero_hold got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo);
      end
      tests_run++;
      if (lat !== 0 || bn !== 1 || {dz, hlw, clr} !== 3'b101) begin
         tests_failed++;
         $display("FAIL div_zero_ctl got lat=%0d busy=%0d dz/hlw/clr=%b want lat=0 busy=1 101",
                  lat, bn, {dz, hlw, clr});
      end
   endtask

   task automatic test_random;
      logic [W-1:0] a, b, hi, lo, mh, ml;
      logic o, dz, hlw, clr, mdz;
      int lat, bn;
      for (int i = 0; i < 60; i++) begin
         o = 1'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = '0;
            1: a = 32'($signed(16'($urandom)));
            2: b = 32'($signed(4'($urandom)));
            3: a = ($urandom_range(0, 1) == 0) ? 32'h80000000 : 32'h7FFFFFFF;
            default: ;
         endcase
         model(o, a, b, mh, ml, mdz);
         run_op(o, a, b, hi, lo, lat, dz, hlw, bn, clr);
         tests_run++;
         if ({hi, lo} !== {mh, ml}) begin
            tests_failed++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h got %h_%h want %h_%h",
                     i, o, a, b, hi, lo, mh, ml);
         end
         tests_run++;
         if (lat !== (mdz ? 0 : W) || bn !== (mdz ? 1 : W + 1) ||
             {dz, hlw, clr} !== {mdz, !mdz, 1'b1}) begin
            tests_failed++;
            $display("FAIL random[%0d] timing got lat=%0d busy=%0d dz/hlw/clr=%b want dz=%0d",
                     i, lat, bn, {dz, hlw, clr}, mdz);
         end
         if (!mdz) begin
            exp_hi = mh;
            exp_lo = ml;
         end
      end
   endtask

   task automatic test_start_during_busy;
      logic [W-1:0] mh, ml;
      logic mdz;
      int lat;
      model(1'b0, 32'd1234, -32'd5678, mh, ml, mdz);
      bus.start = 1'b1;
      bus.op = 1'b0;
      bus.a_in = 32'd1234;
      bus.b_in = -32'd5678;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op = 1'b1;
      bus.a_in = 32'd99;
      bus.b_in = 32'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 5;
      while (!bus.done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      tests_run++;
      if (lat !== W || bus.div_zero !== 1'b0 ||
          {bus.hi_out, bus.lo_out} !== {mh, ml}) begin
         tests_failed++;
         $display("FAIL start_busy got lat=%0d dz=%b %h_%h want lat=%0d dz=0 %h_%h",
                  lat, bus.div_zero, bus.hi_out, bus.lo_out, W, mh, ml);
      end
      exp_hi = mh;
      exp_lo = ml;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_op;
      logic [W-1:0] hi, lo;
      logic dz, hlw, clr;
      int lat, bn, pulses;
      bus.start = 1'b1;
      bus.op = 1'b0;
      bus.a_in = 32'h00007FFF;
      bus.b_in = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      tests_run++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          {bus.hi_out, bus.lo_out} !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset_mid got busy=%b done=%b %h_%h want 0 0 0",
                  bus.busy, bus.done, bus.hi_out, bus.lo_out);
      end
      exp_hi = '0;
      exp_lo = '0;
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done || bus.hi_lo_write || bus.busy) pulses++;
      end
      tests_run++;
      if (pulses !== 0) begin
         tests_failed++;
         $display("FAIL reset_abort got %0d active cycles want 0", pulses);
      end
      run_op(1'b0, 32'd3, 32'd4, hi, lo, lat, dz, hlw, bn, clr);
      tests_run++;
      if ({hi, lo} !== 64'h0000000C || lat !== W) begin
         tests_failed++;
         $display("FAIL after_reset got %h_%h lat=%0d want 0_C lat=%0d",
                  hi, lo, lat, W);
      end
      exp_hi = hi;
      exp_lo = lo;
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] hi, lo, mh, ml;
      logic dz, hlw, clr, mdz;
      int lat, bn;
      logic [W-1:0] a, b;
      for (int i = 0; i < 4; i++) begin
         a = $urandom;
         b = $urandom | 32'h1;
         model(1'(i), a, b, mh, ml, mdz);
         run_op(1'(i), a, b, hi, lo, lat, dz, hlw, bn, clr);
         tests_run++;
         if ({hi, lo} !== {mh, ml} || lat !== W) begin
            tests_failed++;
            $display("FAIL b2b[%0d] got %h_%h lat=%0d want %h_%h lat=%0d",
                     i, hi, lo, lat, mh, ml, W);
         end
         exp_hi = mh;
         exp_lo = ml;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_zero();
      test_random();
      test_start_during_busy();
      test_reset_mid_op();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
